// File: rtl/mon_dispatch.sv
// Round-robin dispatcher and in-order collector. It shares NUM_MON golden-model lanes across one DUT
// transaction stream and retires one compare event per transaction, in acceptance order.
module mon_dispatch #(
    parameter int WIDTH   = 32,
    parameter int NUM_MON = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    input  logic [WIDTH-1:0]           in_dut_os,
    output logic [NUM_MON-1:0]         lane_valid,
    input  logic [NUM_MON-1:0]         lane_ready,
    output logic [NUM_MON*WIDTH-1:0]   lane_a,
    output logic [NUM_MON*WIDTH-1:0]   lane_b,
    input  logic [NUM_MON-1:0]         lane_res_valid,
    input  logic [NUM_MON*WIDTH-1:0]   lane_res,
    output logic                       o_event_valid,
    output logic                       o_event,
    output logic                       o_event_timeout,
    output logic [WIDTH-1:0]           o_event_exp,
    output logic [WIDTH-1:0]           o_event_got,
    output logic [WIDTH-1:0]           o_txn_count,
    output logic [WIDTH-1:0]           o_err_count,
    output logic                       o_idle
);

    localparam int PW = $clog2(NUM_MON);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } slot_state_t;

    slot_state_t      st_r    [NUM_MON];
    logic [WIDTH-1:0] a_r     [NUM_MON];
    logic [WIDTH-1:0] b_r     [NUM_MON];
    logic [WIDTH-1:0] dut_r   [NUM_MON];
    logic [WIDTH-1:0] res_r   [NUM_MON];
    logic             to_r    [NUM_MON];
    logic [TW-1:0]    timer_r [NUM_MON];
    logic [PW-1:0]    disp_ptr_r;
    logic [PW-1:0]    ret_ptr_r;
    logic             accept_s;
    logic             retire_s;
    logic             mismatch_s;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(NUM_MON - 1)) ? '0 : p + PW'(1);
    endfunction

    // in_ready looks only at registered slot state, so a slot freed this edge is reusable next cycle
    assign in_ready   = (st_r[disp_ptr_r] == S_IDLE);
    assign accept_s   = in_valid & in_ready;
    assign retire_s   = (st_r[ret_ptr_r] == S_DONE);
    assign mismatch_s = to_r[ret_ptr_r] | (res_r[ret_ptr_r] != dut_r[ret_ptr_r]);

    // Lane-facing decode of slot state and contents
    always_comb begin
        lane_valid = '0;
        lane_a     = '0;
        lane_b     = '0;
        o_idle     = 1'b1;
        for (int i = 0; i < NUM_MON; i++) begin
            lane_valid[i]              = (st_r[i] == S_ISSUE);
            lane_a[i*WIDTH +: WIDTH]   = a_r[i];
            lane_b[i*WIDTH +: WIDTH]   = b_r[i];
            if (st_r[i] != S_IDLE) begin
                o_idle = 1'b0;
            end else begin
                o_idle = o_idle;
            end
        end
    end

    // Per-slot state machines: capture, issue handshake, response/timeout, retire
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_MON; i++) begin
                st_r[i]    <= S_IDLE;
                a_r[i]     <= '0;
                b_r[i]     <= '0;
                dut_r[i]   <= '0;
                res_r[i]   <= '0;
                to_r[i]    <= 1'b0;
                timer_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_MON; i++) begin
                case (st_r[i])
                    S_IDLE: begin
                        if (accept_s && (disp_ptr_r == PW'(i))) begin
                            a_r[i]   <= in_a;
                            b_r[i]   <= in_b;
                            dut_r[i] <= in_dut_os;
                            st_r[i]  <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        if (lane_ready[i]) begin
                            st_r[i]    <= S_WAIT;
                            timer_r[i] <= '0;
                        end
                    end
                    S_WAIT: begin
                        if (lane_res_valid[i]) begin
                            res_r[i] <= lane_res[i*WIDTH +: WIDTH];
                            to_r[i]  <= 1'b0;
                            st_r[i]  <= S_DONE;
                        end else if (timer_r[i] == TW'(TIMEOUT - 1)) begin
                            res_r[i] <= '0;
                            to_r[i]  <= 1'b1;
                            st_r[i]  <= S_DONE;
                        end else begin
                            timer_r[i] <= timer_r[i] + TW'(1);
                        end
                    end
                    S_DONE: begin
                        if (retire_s && (ret_ptr_r == PW'(i))) begin
                            st_r[i] <= S_IDLE;
                        end
                    end
                    default: st_r[i] <= S_IDLE;
                endcase
            end
        end
    end

    // Dispatch and retire pointers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disp_ptr_r <= '0;
            ret_ptr_r  <= '0;
        end else begin
            if (accept_s) begin
                disp_ptr_r <= next_ptr(disp_ptr_r);
            end
            if (retire_s) begin
                ret_ptr_r <= next_ptr(ret_ptr_r);
            end
        end
    end

    // Event outputs and counters; fields other than the strobe hold between events
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_event_valid   <= 1'b0;
            o_event         <= 1'b0;
            o_event_timeout <= 1'b0;
            o_event_exp     <= '0;
            o_event_got     <= '0;
            o_txn_count     <= '0;
            o_err_count     <= '0;
        end else if (retire_s) begin
            o_event_valid   <= 1'b1;
            o_event         <= mismatch_s;
            o_event_timeout <= to_r[ret_ptr_r];
            o_event_exp     <= res_r[ret_ptr_r];
            o_event_got     <= dut_r[ret_ptr_r];
            o_txn_count     <= o_txn_count + WIDTH'(1);
            if (mismatch_s && (o_err_count != '1)) begin
                o_err_count <= o_err_count + WIDTH'(1);
            end
        end else begin
            o_event_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mon_dispatch.sv
// Bench for mon_dispatch: the lanes act as a+b golden models, and a scoreboard holds the expected events in acceptance order.
module tb_mon_dispatch;
    localparam int W  = 32;
    localparam int NM = 2;
    localparam int TO = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_a, in_b, in_dut_os;
    logic [NM-1:0]     lane_valid, lane_ready, lane_res_valid;
    logic [NM*W-1:0]   lane_a, lane_b, lane_res;
    logic              o_event_valid, o_event, o_event_timeout, o_idle;
    logic [W-1:0]      o_event_exp, o_event_got, o_txn_count, o_err_count;

    mon_dispatch #(.WIDTH(W), .NUM_MON(NM), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_dut_os(in_dut_os),
        .lane_valid(lane_valid), .lane_ready(lane_ready), .lane_a(lane_a), .lane_b(lane_b),
        .lane_res_valid(lane_res_valid), .lane_res(lane_res),
        .o_event_valid(o_event_valid), .o_event(o_event), .o_event_timeout(o_event_timeout),
        .o_event_exp(o_event_exp), .o_event_got(o_event_got),
        .o_txn_count(o_txn_count), .o_err_count(o_err_count), .o_idle(o_idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] exp;
        logic [W-1:0] got;
        logic         to;
        logic         ev;
    } exp_t;

    exp_t         sb[$];
    int           ev_ticks[$];
    int           acc_ticks[$];
    int           checks = 0;
    int           errors = 0;
    int           tick_n = 0;
    int           acc_idx = 0;
    int           lat_cfg[NM];
    int           cnt[NM];
    logic         pend[NM];
    logic [W-1:0] rsum[NM];
    int           hs_tick[NM];
    int           last_hs_lane = -1;
    logic [W-1:0] txn_m = '0;
    logic [W-1:0] err_m = '0;
    bit           rand_ready = 1'b0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: pre-edge observations, the edge, then output checks and lane responses for the next edge
    task automatic tick();
        exp_t         e;
        int           lane;
        logic [W-1:0] s;
        if (reset && in_valid && in_ready) begin
            lane  = acc_idx % NM;
            s     = in_a + in_b;
            e.to  = (lat_cfg[lane] > TO);
            e.exp = e.to ? '0 : s;
            e.got = in_dut_os;
            e.ev  = e.to || (s != in_dut_os);
            sb.push_back(e);
            acc_ticks.push_back(tick_n + 1);
            acc_idx++;
        end
        for (int i = 0; i < NM; i++) begin
            if (reset && lane_valid[i] && lane_ready[i]) begin
                pend[i]      = 1'b1;
                cnt[i]       = (lat_cfg[i] == 0) ? int'($urandom_range(1, 8)) : lat_cfg[i];
                rsum[i]      = lane_a[i*W +: W] + lane_b[i*W +: W];
                hs_tick[i]   = tick_n + 1;
                last_hs_lane = i;
            end
        end
        @(negedge clk);
        tick_n++;
        if (o_event_valid) begin
            ev_ticks.push_back(tick_n);
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_event observed event at tick %0d expected none", tick_n);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("ev_flag", o_event, e.ev);
                chk("ev_timeout", o_event_timeout, e.to);
                chk("ev_exp", o_event_exp, e.exp);
                chk("ev_got", o_event_got, e.got);
                txn_m = txn_m + 1;
                if (e.ev && err_m != '1) err_m = err_m + 1;
            end
            chk("txn_count", o_txn_count, txn_m);
            chk("err_count", o_err_count, err_m);
        end
        for (int i = 0; i < NM; i++) begin
            lane_res_valid[i] = 1'b0;
            if (!reset) begin
                pend[i] = 1'b0;
            end else if (pend[i]) begin
                cnt[i]--;
                if (cnt[i] == 0) begin
                    lane_res_valid[i]  = 1'b1;
                    lane_res[i*W +: W] = rsum[i];
                    pend[i]            = 1'b0;
                end
            end
        end
        if (rand_ready) lane_ready = NM'($urandom_range(0, (1 << NM) - 1));
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] d);
        logic acc;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_dut_os = d;
        acc       = 1'b0;
        for (int k = 0; k < 300 && !acc; k++) begin
            acc = in_ready;
            tick();
        end
        checks++;
        assert (acc) else begin
            errors++;
            $error("FAIL send_timeout observed no accept expected accept");
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            tick();
            done = (sb.size() == 0) && o_idle;
        end
        checks++;
        assert (done) else begin
            errors++;
            $error("FAIL drain_timeout observed %0d pending expected 0", sb.size());
        end
    endtask

    initial begin
        logic         acc;
        logic [W-1:0] a, b;
        reset          = 1'b0;
        in_valid       = 1'b0;
        in_a           = '0;
        in_b           = '0;
        in_dut_os      = '0;
        lane_ready     = '0;
        lane_res_valid = '0;
        lane_res       = '0;
        for (int i = 0; i < NM; i++) begin
            lat_cfg[i] = 1;
            pend[i]    = 1'b0;
            cnt[i]     = 0;
            hs_tick[i] = 0;
        end
        repeat (3) tick();
        chk("rst_event_valid", o_event_valid, 1'b0);
        chk("rst_txn", o_txn_count, '0);
        chk("rst_err", o_err_count, '0);
        chk("rst_idle", o_idle, 1'b1);
        chk("rst_lane_valid", lane_valid, '0);
        chk("rst_exp", o_event_exp, '0);
        reset = 1'b1;
        tick();
        chk("rst_in_ready", in_ready, 1'b1);

        // Four transactions, lanes always ready, one-cycle model latency
        lane_ready = '1;
        ev_ticks.delete();
        acc_ticks.delete();
        for (int i = 0; i < 4; i++) begin
            a = W'(i * 16 + 1);
            b = W'(i + 2);
            send(a, b, a + b);
        end
        drain();
        chk("t1_events", W'(ev_ticks.size()), W'(4));
        chk("t1_txn", o_txn_count, W'(4));
        chk("t1_err", o_err_count, W'(0));
        chk("t1_min_latency", W'(ev_ticks[0]), W'(acc_ticks[0] + 3));

        // Slow lane 0, fast lane 1: B completes first but retires after A
        lat_cfg[0] = 10;
        lat_cfg[1] = 1;
        ev_ticks.delete();
        send(W'(100), W'(1), W'(101));
        send(W'(200), W'(2), W'(202));
        drain();
        chk("t2_a_latency", W'(ev_ticks[0]), W'(hs_tick[0] + 11));
        chk("t2_b_after_a", W'(ev_ticks[1]), W'(ev_ticks[0] + 1));

        // Mismatch 3+5 vs DUT 9
        lat_cfg[0] = 1;
        send(W'(3), W'(5), W'(9));
        drain();
        chk("t3_event", o_event, 1'b1);
        chk("t3_exp", o_event_exp, W'(8));
        chk("t3_got", o_event_got, W'(9));
        chk("t3_err", o_err_count, W'(1));

        // Lane 0 never answers in time; its late answer must be ignored
        send(W'(1), W'(1), W'(2));
        lat_cfg[0] = 70;
        ev_ticks.delete();
        send(W'(40), W'(2), W'(42));
        drain();
        chk("t4_timeout_tick", W'(ev_ticks[ev_ticks.size() - 1]), W'(hs_tick[0] + TO + 1));
        chk("t4_timeout_flag", o_event_timeout, 1'b1);
        chk("t4_exp_zero", o_event_exp, W'(0));
        chk("t4_event", o_event, 1'b1);
        repeat (12) tick();
        chk("t4_late_ignored", o_txn_count, txn_m);
        chk("t4_idle", o_idle, 1'b1);
        lat_cfg[0] = 1;

        // Full condition with lanes stalled
        lane_ready = '0;
        send(W'(5), W'(6), W'(11));
        send(W'(7), W'(8), W'(15));
        in_valid  = 1'b1;
        in_a      = W'(9);
        in_b      = W'(10);
        in_dut_os = W'(19);
        repeat (5) tick();
        chk("t5_full_ready", in_ready, 1'b0);
        chk("t5_lane_valid", lane_valid, 2'b11);
        lane_ready = '1;
        ev_ticks.delete();
        acc_ticks.delete();
        acc = 1'b0;
        for (int k = 0; k < 50 && !acc; k++) begin
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        drain();
        chk("t5_accept_after_retire", W'(acc_ticks[0]), W'(ev_ticks[0] + 1));

        // Randomized traffic with random readiness and latency
        rand_ready = 1'b1;
        lat_cfg[0] = 0;
        lat_cfg[1] = 0;
        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            b = $urandom;
            send(a, b, ($urandom_range(0, 1) == 1) ? a + b : $urandom);
            repeat ($urandom_range(0, 3)) tick();
        end
        drain();
        rand_ready = 1'b0;
        lane_ready = '1;
        chk("t6_txn", o_txn_count, txn_m);

        // Reset with two slots waiting on their lanes
        lat_cfg[0] = 40;
        lat_cfg[1] = 40;
        send(W'(1), W'(2), W'(3));
        send(W'(4), W'(5), W'(9));
        repeat (4) tick();
        chk("t7_busy", o_idle, 1'b0);
        reset = 1'b0;
        tick();
        sb.delete();
        acc_idx = 0;
        txn_m   = '0;
        err_m   = '0;
        tick();
        chk("t7_ev_valid", o_event_valid, 1'b0);
        chk("t7_txn", o_txn_count, W'(0));
        chk("t7_err", o_err_count, W'(0));
        chk("t7_idle", o_idle, 1'b1);
        chk("t7_lane_valid", lane_valid, '0);
        reset = 1'b1;
        repeat (50) tick();
        chk("t7_no_events", o_txn_count, W'(0));
        lat_cfg[0] = 1;
        lat_cfg[1] = 1;
        send(W'(7), W'(7), W'(14));
        chk("t7_fresh_lane0", lane_valid, 2'b01);
        drain();
        chk("t7_hs_lane", W'(last_hs_lane), W'(0));
        chk("t7_txn_after", o_txn_count, W'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
